// File: rtl/pipeline_controller_pkg.sv
// Shared types, control encodings and the RUN-state priority decision for the pipeline controller.
package pipeline_controller_pkg;

    typedef enum logic [1:0] {
        PC_RUN        = 2'd0,
        PC_LOAD_STALL = 2'd1,
        PC_MC_WAIT    = 2'd2,
        PC_MEM_WAIT   = 2'd3
    } pipe_ctrl_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic fetch_write;
        logic make_bubble;
        logic if_flush;
        logic ex_hold;
    } pipe_ctrl_t;

    typedef struct packed {
        pipe_ctrl_t       ctl;
        pipe_ctrl_state_t nxt;
        logic             wait_load;
    } run_decision_t;

    localparam pipe_ctrl_t CTRL_ADVANCE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam pipe_ctrl_t CTRL_BUBBLE  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_FLUSH   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_RESET   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Priority order used by RUN and by every state that falls back to RUN behaviour.
    function automatic run_decision_t run_rules(
        input logic mem_wait,
        input logic mc_start,
        input logic load_use,
        input logic branch_taken
    );
        run_decision_t d;
        d.ctl       = CTRL_ADVANCE;
        d.nxt       = PC_RUN;
        d.wait_load = 1'b0;
        if (mem_wait) begin
            d.ctl = CTRL_FREEZE;
            d.nxt = PC_MEM_WAIT;
        end else if (mc_start) begin
            d.ctl       = CTRL_FREEZE;
            d.nxt       = PC_MC_WAIT;
            d.wait_load = 1'b1;
        end else if (load_use) begin
            d.ctl = CTRL_BUBBLE;
            d.nxt = PC_LOAD_STALL;
        end else if (branch_taken) begin
            d.ctl = CTRL_FLUSH;
        end else begin
            d.ctl = CTRL_ADVANCE;
        end
        return d;
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in ID (x0 never hazards).
module load_use_detector
    import pipeline_controller_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       id_ex_MemRead,
    input  logic [4:0] id_ex_rd,
    output logic       load_use
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    assign rs1_hit_s = id_uses_rs1 && (id_rs1 == id_ex_rd);
    assign rs2_hit_s = id_uses_rs2 && (id_rs2 == id_ex_rd);
    assign load_use  = id_ex_MemRead && (id_ex_rd != REG_X0) && (rs1_hit_s || rs2_hit_s);

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer: registered state, wait counter, statistics and watchdog flag;
// pipeline enables are decoded combinationally from the current state and inputs.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_ex_MemRead,
    input  logic [4:0]       id_ex_rd,
    input  logic             branch_taken,
    input  logic             mc_start,
    input  logic             mc_done,
    input  logic             mem_wait,
    output logic             PCWrite,
    output logic             FetchWrite,
    output logic             MakeBubble,
    output logic             if_flush,
    output logic             ex_hold,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mc_timeout
);

    localparam int              WC_W     = $clog2(MC_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_ZERO  = {WC_W{1'b0}};
    localparam logic [WC_W-1:0] WC_ONE   = {{(WC_W-1){1'b0}}, 1'b1};
    localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(MC_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_ctrl_state_t state_r;
    pipe_ctrl_state_t state_nxt_s;
    logic [WC_W-1:0]  wait_cnt_r;
    logic [WC_W-1:0]  wait_cnt_nxt_s;
    logic [CNT_W-1:0] stall_count_r;
    logic [CNT_W-1:0] flush_count_r;
    logic             mc_timeout_r;
    logic             timeout_hit_s;
    logic             load_use_s;
    pipe_ctrl_t       ctl_s;
    run_decision_t    run_s;

    load_use_detector u_load_use_detector (
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .id_ex_MemRead (id_ex_MemRead),
        .id_ex_rd      (id_ex_rd),
        .load_use      (load_use_s)
    );

    // Enable decode and next-state selection from current state and inputs.
    always_comb begin
        ctl_s          = CTRL_ADVANCE;
        state_nxt_s    = PC_RUN;
        wait_cnt_nxt_s = wait_cnt_r;
        timeout_hit_s  = 1'b0;
        run_s          = run_rules(1'b0, 1'b0, 1'b0, 1'b0);
        if (rst) begin
            ctl_s = CTRL_RESET;
        end else begin
            case (state_r)
                PC_RUN, PC_LOAD_STALL: begin
                    // Right after a bubble the same load is still visible; one bubble is enough.
                    if (state_r == PC_LOAD_STALL) begin
                        run_s = run_rules(mem_wait, mc_start, 1'b0, branch_taken);
                    end else begin
                        run_s = run_rules(mem_wait, mc_start, load_use_s, branch_taken);
                    end
                    ctl_s       = run_s.ctl;
                    state_nxt_s = run_s.nxt;
                    if (run_s.wait_load) begin
                        wait_cnt_nxt_s = WC_ONE;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r;
                    end
                end
                PC_MC_WAIT: begin
                    if (mc_done) begin
                        ctl_s          = CTRL_ADVANCE;
                        ctl_s.if_flush = branch_taken;
                        state_nxt_s    = PC_RUN;
                    end else if (wait_cnt_r == WC_LIMIT) begin
                        ctl_s         = CTRL_ADVANCE;
                        timeout_hit_s = 1'b1;
                        state_nxt_s   = PC_RUN;
                    end else begin
                        ctl_s          = CTRL_FREEZE;
                        state_nxt_s    = PC_MC_WAIT;
                        wait_cnt_nxt_s = wait_cnt_r + WC_ONE;
                    end
                end
                PC_MEM_WAIT: begin
                    if (mem_wait) begin
                        ctl_s       = CTRL_FREEZE;
                        state_nxt_s = PC_MEM_WAIT;
                    end else begin
                        run_s       = run_rules(1'b0, mc_start, load_use_s, branch_taken);
                        ctl_s       = run_s.ctl;
                        state_nxt_s = run_s.nxt;
                        if (run_s.wait_load) begin
                            wait_cnt_nxt_s = WC_ONE;
                        end else begin
                            wait_cnt_nxt_s = wait_cnt_r;
                        end
                    end
                end
                default: begin
                    ctl_s       = CTRL_FREEZE;
                    state_nxt_s = PC_RUN;
                end
            endcase
        end
    end

    // State, wait counter, saturating statistics and sticky watchdog flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= PC_RUN;
            wait_cnt_r    <= WC_ZERO;
            stall_count_r <= CNT_ZERO;
            flush_count_r <= CNT_ZERO;
            mc_timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (!ctl_s.pc_write && !(&stall_count_r)) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end
            if (ctl_s.if_flush && !(&flush_count_r)) begin
                flush_count_r <= flush_count_r + CNT_ONE;
            end else begin
                flush_count_r <= flush_count_r;
            end
            if (timeout_hit_s) begin
                mc_timeout_r <= 1'b1;
            end else begin
                mc_timeout_r <= mc_timeout_r;
            end
        end
    end

    assign PCWrite     = ctl_s.pc_write;
    assign FetchWrite  = ctl_s.fetch_write;
    assign MakeBubble  = ctl_s.make_bubble;
    assign if_flush    = ctl_s.if_flush;
    assign ex_hold     = ctl_s.ex_hold;
    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;
    assign mc_timeout  = mc_timeout_r;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench: each step queues the expected enables and counters, compared at the falling edge.
module tb_pipeline_controller;

    localparam int CNT_W = 5;
    localparam int TMO   = 12;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    // {PCWrite, FetchWrite, MakeBubble, if_flush, ex_hold}
    localparam logic [4:0] ADV  = 5'b11000;
    localparam logic [4:0] FRZ  = 5'b00001;
    localparam logic [4:0] BUB  = 5'b00100;
    localparam logic [4:0] FLS  = 5'b11010;
    localparam logic [4:0] RSTV = 5'b00110;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_ex_MemRead;
    logic [4:0]       id_ex_rd;
    logic             branch_taken;
    logic             mc_start;
    logic             mc_done;
    logic             mem_wait;
    logic             PCWrite;
    logic             FetchWrite;
    logic             MakeBubble;
    logic             if_flush;
    logic             ex_hold;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             mc_timeout;

    typedef struct {
        logic [4:0]       ctl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        logic             to;
        bit               cnt_valid;
    } exp_t;

    exp_t             exp_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic [CNT_W-1:0] m_sc = '0;
    logic [CNT_W-1:0] m_fc = '0;
    logic             m_to = 1'b0;
    bit               m_valid = 1'b0;

    pipeline_controller #(.MC_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .id_ex_MemRead (id_ex_MemRead),
        .id_ex_rd      (id_ex_rd),
        .branch_taken  (branch_taken),
        .mc_start      (mc_start),
        .mc_done       (mc_done),
        .mem_wait      (mem_wait),
        .PCWrite       (PCWrite),
        .FetchWrite    (FetchWrite),
        .MakeBubble    (MakeBubble),
        .if_flush      (if_flush),
        .ex_hold       (ex_hold),
        .stall_count   (stall_count),
        .flush_count   (flush_count),
        .mc_timeout    (mc_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Hazard scenarios: 1 rs1 hit, 2 rd=x0, 3 rs2 hit, 4 rs1 match unused, 5 not a load, 6 load no match.
    task automatic set_hazard(input int hz);
        id_ex_MemRead = 1'b0; id_ex_rd = 5'd5; id_rs1 = 5'd1; id_rs2 = 5'd2;
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        case (hz)
            1: begin id_ex_MemRead = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; end
            2: begin id_ex_MemRead = 1'b1; id_ex_rd = 5'd0; id_rs1 = 5'd0; end
            3: begin id_ex_MemRead = 1'b1; id_ex_rd = 5'd7; id_rs2 = 5'd7; end
            4: begin id_ex_MemRead = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b0; end
            5: begin id_ex_MemRead = 1'b0; id_ex_rd = 5'd5; id_rs1 = 5'd5; end
            6: begin id_ex_MemRead = 1'b1; id_ex_rd = 5'd9; id_rs1 = 5'd3; id_rs2 = 5'd4; end
            default: id_ex_MemRead = 1'b0;
        endcase
    endtask

    task automatic step(input logic r, input int hz, input logic br, input logic mcs,
                        input logic mcd, input logic mw, input logic [4:0] eo, input string tag);
        exp_t e;
        rst = r; set_hazard(hz); branch_taken = br; mc_start = mcs; mc_done = mcd; mem_wait = mw;
        e.ctl = eo; e.sc = m_sc; e.fc = m_fc; e.to = m_to; e.cnt_valid = m_valid;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq({tag, ".ctl"}, 32'({PCWrite, FetchWrite, MakeBubble, if_flush, ex_hold}), 32'(e.ctl));
        if (e.cnt_valid) begin
            check_eq({tag, ".stall_count"}, 32'(stall_count), 32'(e.sc));
            check_eq({tag, ".flush_count"}, 32'(flush_count), 32'(e.fc));
            check_eq({tag, ".mc_timeout"}, 32'(mc_timeout), 32'(e.to));
        end
        if (r) begin
            m_sc = '0; m_fc = '0; m_to = 1'b0; m_valid = 1'b1;
        end else begin
            if (!eo[4] && m_sc != CMAX) m_sc = m_sc + 1'b1;
            if (eo[1] && m_fc != CMAX) m_fc = m_fc + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; set_hazard(0); branch_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0; mem_wait = 1'b0;
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, RSTV, "reset0");
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, RSTV, "reset1");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "idle");
        // Load-use hazards
        step(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, BUB,  "lu_rs1");
        step(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "lu_once");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "lu_after");
        step(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "lu_x0");
        step(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, BUB,  "lu_rs2");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "lu_rs2_after");
        step(1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "lu_unused");
        step(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "lu_noload");
        step(1'b0, 6, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "lu_nomatch");
        // Branches
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, FLS,  "br_run");
        step(1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, BUB,  "br_vs_lu");
        step(1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, FLS,  "br_in_lstall");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "br_after");
        // Divide finishing on the tenth cycle after start
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  "div_start");
        repeat (9) step(1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, FRZ, "div_wait");
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, ADV,  "div_done");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "div_after");
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  "div2_start");
        step(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, FLS,  "div2_done_br");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "div2_after");
        // Priority and MEM_WAIT release
        step(1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, FRZ,  "prio_all");
        step(1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, FRZ,  "mem_hold");
        step(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, BUB,  "mem_rel_lu");
        step(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "mem_rel_after");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ,  "mem2");
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  "mem2_rel_mc");
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, ADV,  "mem2_mc_done");
        // mc_done on the timeout cycle wins (branch honoured, no flag)
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  "dw_start");
        repeat (TMO - 1) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ, "dw_wait");
        step(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, FLS,  "dw_done");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "dw_after");
        // Watchdog timeout
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  "to_start");
        repeat (TMO - 1) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ, "to_wait");
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, ADV,  "to_fire");
        m_to = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "to_sticky");
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  "to_mc");
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, ADV,  "to_mc_done");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "to_sticky2");
        // Counter saturation
        repeat (35) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ, "sat_stall");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "sat_stall_rel");
        repeat (35) step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, FLS, "sat_flush");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "sat_after");
        // Reset while waiting
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  "rmc_start");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ,  "rmc_wait");
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, RSTV, "rmc_rst");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "rmc_run");
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, ADV,  "rmc_stray_done");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ,  "rmw_mem");
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, RSTV, "rmw_rst");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "rmw_run");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ADV,  "final");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
